multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Moore main-control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory access and write-back over one shared ALU, register file and unified memory.
- Drives the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 subtract, 10 use funct), plus all mux selects and write enables.
- Waits on a memory ready handshake for every memory access.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load-word opcode
- OP_SW, 6'b101011, store-word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  6  opcode field from instruction register (IR[31:26])
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current access this cycle
- pc_en  output  1  PC register write enable
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- RegDst  output  1  destination register select: 0 = rt, 1 = rd
- MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  output  2  to ALU control decoder
- PCSrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded
- state_o  output  4  current state, for debug and verification

Behaviour:
- Single state register, asynchronous reset to FETCH.
- While rst_n is low, every output is 0 and state_o = FETCH (0).
- All outputs decode from state only, except two terms:
  - pc_en also depends on zero (in BEQ) and on mem_ready (in FETCH).
  - IRWrite depends on mem_ready.
- Outputs not listed for a state are 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, AEX=9, AWB=10, JMP=11. Values 12-15 are unreachable and transition to FETCH with all outputs 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = pc_en = mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes branch target).
  - Next state by op: LW or SW -> MEMADR; RTYPE -> REX; BEQ -> BEQ; ADDI -> AEX; J -> JMP.
  - Any other op -> FETCH, with illegal_op=1 for this single cycle.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEMRD if op=LW, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, then goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then goes to FETCH.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then goes to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, then goes to FETCH.
- BEQ:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01.
  - pc_en = zero.
  - Goes to FETCH.
- AEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then goes to AWB.
- AWB: RegWrite=1, RegDst=0, MemtoReg=0, then goes to FETCH.
- JMP: PCSrc=10, pc_en=1, then goes to FETCH.
- Latency with zero-wait memory (mem_ready=1 on the first cycle):
  - lw = 5 cycles
  - sw, R-type and addi = 4 cycles
  - beq and j = 3 cycles
  - Each additional cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Memory handshake:
  - MemRead/MemWrite stay asserted and the address select stays stable until mem_ready is seen.
  - mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset mid-instruction:
  - Any partially executed instruction is abandoned with no register or memory write.
  - After release, the first clock edge is evaluated in FETCH.
- op is sampled only in DECODE and MEMADR. The IR holds op stable because IRWrite=0 outside FETCH.

Test Plan:
- Reset asserted mid-MEMRD, mem_ready=1 -> all outputs 0 during reset; state_o=0 on release; first FETCH with mem_ready=1 gives IRWrite=1, pc_en=1.
- R-type: op=000000, mem_ready=1 -> state_o sequence 0,1,6,7,0; ALUOp=10 in REX; RegWrite=1 and RegDst=1 only in RWB.
- lw with 2 wait cycles in MEMRD: op=100011 -> states 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 held for 3 cycles; MemtoReg=1 and RegWrite=1 in MEMWB.
- beq: op=000100 with zero=1 -> pc_en=1, PCSrc=01, ALUOp=01 in state 8. Repeat with zero=0 -> pc_en=0 in state 8.
- sw, then j: op=101011 -> MemWrite=1 for exactly one cycle with RegWrite never asserted; then op=000010 -> states 0,1,11 with pc_en=1 and PCSrc=10.
- Illegal op: op=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state 0, no write enable asserted. FETCH held with mem_ready=0 for 4 cycles -> IRWrite=0 and pc_en=0 throughout.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_control_if
// Brief    : Control/status bundle between the multicycle MIPS main-control
//            FSM (master) and the datapath it steers (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_main_control_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  op, zero, mem_ready,
        output pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op, state_o
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op, state_o
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_control
// Brief    : Moore main-control FSM for the multicycle MIPS datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                         clk,
    input  logic                         rst_n,
    multicycle_main_control_if.master    bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_AEX    = 4'd9,
        S_AWB    = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_en, w_iord, w_memread, w_memwrite, w_irwrite;
    logic       w_regdst, w_memtoreg, w_regwrite, w_alusrca, w_illegal;
    logic [1:0] w_alusrcb, w_aluop, w_pcsrc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pc_en    = 1'b0;
        w_iord     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_illegal  = 1'b0;
        w_alusrcb  = 2'b00;
        w_aluop    = 2'b00;
        w_pcsrc    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                w_irwrite = bus.mem_ready;
                w_pc_en   = bus.mem_ready;
                w_next    = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                w_alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_REX;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_ADDI:      w_next = S_AEX;
                    OP_J:         w_next = S_JMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                w_next    = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                w_next     = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_REX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_RWB;
            end
            S_RWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            S_BEQ: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_pc_en   = bus.zero;
            end
            S_AEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_AWB;
            end
            S_AWB: begin
                w_regwrite = 1'b1;
            end
            S_JMP: begin
                w_pcsrc = 2'b10;
                w_pc_en = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // FETCH would otherwise request memory while reset is held
    assign bus.pc_en      = rst_n & w_pc_en;
    assign bus.IorD       = rst_n & w_iord;
    assign bus.MemRead    = rst_n & w_memread;
    assign bus.MemWrite   = rst_n & w_memwrite;
    assign bus.IRWrite    = rst_n & w_irwrite;
    assign bus.RegDst     = rst_n & w_regdst;
    assign bus.MemtoReg   = rst_n & w_memtoreg;
    assign bus.RegWrite   = rst_n & w_regwrite;
    assign bus.ALUSrcA    = rst_n & w_alusrca;
    assign bus.illegal_op = rst_n & w_illegal;
    assign bus.ALUSrcB    = {2{rst_n}} & w_alusrcb;
    assign bus.ALUOp      = {2{rst_n}} & w_aluop;
    assign bus.PCSrc      = {2{rst_n}} & w_pcsrc;
    assign bus.state_o    = r_state;

endmodule
`default_nettype wire
